// File: rtl/multi_way_blockram_pkg.sv
// Shared state encoding and default geometry for the multi-way set store.
package multi_way_blockram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int DEF_ELEM_W      = 10;
  localparam int DEF_NUMBER_SETS = 64;
  localparam int DEF_SET_PTR_W   = 6;
  localparam int DEF_NUMBER_WAYS = 4;
  localparam int DEF_WAY_PTR_W   = 2;
  localparam int DEF_INIT_VALUE  = 0;

endpackage

// File: rtl/multi_way_blockram_way_bank.sv
// One way of the set store: simple dual-port RAM, write port returns the
// overwritten word (read-before-write), read port registered with enable.
module way_bank #(
  parameter int W     = 10,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk_in,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  old_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) begin
      old_data      <= mem[wr_addr];
      mem[wr_addr]  <= wr_data;
    end
  end

endmodule

// File: rtl/multi_way_blockram.sv
// Set-associative element store: init sweep, 1-cycle set read with
// write-first bypass, and 1-cycle evict of the overwritten way.
module multi_way_blockram
  import multi_way_blockram_pkg::*;
#(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = DEF_ELEM_W,
  parameter int NUMBER_SETS                 = DEF_NUMBER_SETS,
  parameter int SET_PTR_WIDTH_IN_BITS       = DEF_SET_PTR_W,
  parameter int NUMBER_WAYS                 = DEF_NUMBER_WAYS,
  parameter int WAY_PTR_WIDTH_IN_BITS       = DEF_WAY_PTR_W,
  parameter int INIT_VALUE                  = DEF_INIT_VALUE
) (
  input  logic                                               clk_in,
  input  logic                                               reset_in,
  output logic                                               init_done_out,
  input  logic                                               read_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                   read_set_addr_in,
  output logic                                               read_valid_out,
  output logic [NUMBER_WAYS*SINGLE_ELEMENT_SIZE_IN_BITS-1:0] read_set_out,
  input  logic                                               write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                   write_set_addr_in,
  input  logic [WAY_PTR_WIDTH_IN_BITS-1:0]                   write_way_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]             write_element_in,
  output logic                                               evict_valid_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]             evict_element_out
);

  localparam int W  = SINGLE_ELEMENT_SIZE_IN_BITS;
  localparam int SW = SET_PTR_WIDTH_IN_BITS;
  localparam int WW = WAY_PTR_WIDTH_IN_BITS;
  localparam logic [W-1:0] INIT_ELEM = W'(INIT_VALUE);

  if (NUMBER_SETS != 2**SW || NUMBER_WAYS > 2**WW) begin : g_bad_cfg
    $error("multi_way_blockram: inconsistent set/way geometry");
  end

  state_t         state_q, state_d;
  logic [SW-1:0]  sweep_q;
  logic           init_wr, ready;
  logic [31:0]    way_ext;
  logic           rd_acc, wr_acc, init_wr_g;
  logic [SW-1:0]  bank_waddr;
  logic [W-1:0]   bank_wdata;
  logic [NUMBER_WAYS-1:0] bank_we;
  logic [W-1:0]   bank_rd [NUMBER_WAYS];
  logic [W-1:0]   bank_ev [NUMBER_WAYS];

  logic           rd_vld_p1, ev_vld_p1, rd_seen_p1, ev_seen_p1, byp_hit_p1;
  logic [WW-1:0]  byp_way_p1, ev_way_p1;
  logic [W-1:0]   byp_data_p1;

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) sweep_q <= sweep_q + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    init_done_out = 1'b0;
    init_wr       = 1'b0;
    ready         = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_wr = 1'b1;
        if (&sweep_q) state_d = ST_READY;
      end
      ST_READY: begin
        init_done_out = 1'b1;
        ready         = 1'b1;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // p0: request acceptance; a reset edge discards everything presented with it
  assign way_ext    = 32'(write_way_in);
  assign rd_acc     = reset_in & ready & read_en_in;
  assign wr_acc     = reset_in & ready & write_en_in & (way_ext < 32'(NUMBER_WAYS));
  assign init_wr_g  = reset_in & init_wr;
  assign bank_waddr = init_wr_g ? sweep_q : write_set_addr_in;
  assign bank_wdata = init_wr_g ? INIT_ELEM : write_element_in;

  for (genvar w = 0; w < NUMBER_WAYS; w++) begin : g_way
    assign bank_we[w] = init_wr_g | (wr_acc & (way_ext == 32'(w)));
    way_bank #(.W(W), .DEPTH(NUMBER_SETS), .AW(SW)) u_bank (
      .clk_in   (clk_in),
      .rd_en    (rd_acc),
      .rd_addr  (read_set_addr_in),
      .rd_data  (bank_rd[w]),
      .wr_en    (bank_we[w]),
      .wr_addr  (bank_waddr),
      .wr_data  (bank_wdata),
      .old_data (bank_ev[w])
    );
  end

  // p1: valid pulses and the bypass/evict selectors captured with the request
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      rd_vld_p1  <= 1'b0;
      ev_vld_p1  <= 1'b0;
      rd_seen_p1 <= 1'b0;
      ev_seen_p1 <= 1'b0;
      byp_hit_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= rd_acc;
      ev_vld_p1 <= wr_acc;
      if (rd_acc) begin
        rd_seen_p1 <= 1'b1;
        byp_hit_p1 <= wr_acc && (write_set_addr_in == read_set_addr_in);
      end
      if (wr_acc) ev_seen_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rd_acc) begin
      byp_way_p1  <= write_way_in;
      byp_data_p1 <= write_element_in;
    end
    if (wr_acc) ev_way_p1 <= write_way_in;
  end

  assign read_valid_out  = rd_vld_p1;
  assign evict_valid_out = ev_vld_p1;

  always_comb begin
    read_set_out      = '0;
    evict_element_out = '0;
    for (int w = 0; w < NUMBER_WAYS; w++) begin
      if (rd_seen_p1)
        read_set_out[w*W +: W] = (byp_hit_p1 && byp_way_p1 == WW'(w)) ? byp_data_p1 : bank_rd[w];
      if (ev_seen_p1 && ev_way_p1 == WW'(w))
        evict_element_out = bank_ev[w];
    end
  end

endmodule

// File: tb/tb_multi_way_blockram.sv
// Directed bench for multi_way_blockram with default geometry (64 sets x 4 ways x 10 bits).
module tb_multi_way_blockram;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        init_done_out;
  logic        read_en_in;
  logic [5:0]  read_set_addr_in;
  logic        read_valid_out;
  logic [39:0] read_set_out;
  logic        write_en_in;
  logic [5:0]  write_set_addr_in;
  logic [1:0]  write_way_in;
  logic [9:0]  write_element_in;
  logic        evict_valid_out;
  logic [9:0]  evict_element_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  multi_way_blockram dut (
    .clk_in            (clk_in),
    .reset_in          (reset_in),
    .init_done_out     (init_done_out),
    .read_en_in        (read_en_in),
    .read_set_addr_in  (read_set_addr_in),
    .read_valid_out    (read_valid_out),
    .read_set_out      (read_set_out),
    .write_en_in       (write_en_in),
    .write_set_addr_in (write_set_addr_in),
    .write_way_in      (write_way_in),
    .write_element_in  (write_element_in),
    .evict_valid_out   (evict_valid_out),
    .evict_element_out (evict_element_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    read_en_in  = 1'b0;
    write_en_in = 1'b0;
  endtask

  task automatic rd(input logic [5:0] s);
    read_en_in       = 1'b1;
    read_set_addr_in = s;
  endtask

  task automatic wr(input logic [5:0] s, input logic [1:0] w, input logic [9:0] d);
    write_en_in       = 1'b1;
    write_set_addr_in = s;
    write_way_in      = w;
    write_element_in  = d;
  endtask

  task automatic wait_init(input string tag);
    int cnt = 0;
    while (!init_done_out && cnt < 200) begin
      tick();
      cnt++;
    end
    check(tag, 64'(cnt), 64'd64);
  endtask

  initial begin
    reset_in = 1'b0;
    idle();
    read_set_addr_in = '0; write_set_addr_in = '0; write_way_in = '0; write_element_in = '0;
    repeat (3) tick();
    check("rst_init_done", 64'(init_done_out), 64'd0);
    check("rst_rd_vld", 64'(read_valid_out), 64'd0);
    check("rst_ev_vld", 64'(evict_valid_out), 64'd0);
    check("rst_rd_set", 64'(read_set_out), 64'd0);
    check("rst_ev_elem", 64'(evict_element_out), 64'd0);

    // Release, then present a write and a read at sweep cycle 10
    reset_in = 1'b1;
    repeat (9) tick();
    wr(6'd0, 2'd0, 10'h3FF);
    rd(6'd0);
    tick();
    idle();
    check("init_req_ev_vld", 64'(evict_valid_out), 64'd0);
    check("init_req_rd_vld", 64'(read_valid_out), 64'd0);
    check("init_req_done", 64'(init_done_out), 64'd0);
    begin
      int cnt = 10;
      while (!init_done_out && cnt < 200) begin
        tick();
        cnt++;
      end
      check("init_latency", 64'(cnt), 64'd64);
    end

    rd(6'd63); tick(); idle();
    check("rd63_vld", 64'(read_valid_out), 64'd1);
    check("rd63_data", 64'(read_set_out), 64'd0);
    tick();
    check("rd_vld_pulse", 64'(read_valid_out), 64'd0);

    rd(6'd0); tick(); idle();
    check("rd0_after_init_req", 64'(read_set_out), 64'd0);

    wr(6'd5, 2'd2, 10'h155); tick(); idle();
    check("w5_ev_vld", 64'(evict_valid_out), 64'd1);
    check("w5_ev_elem", 64'(evict_element_out), 64'd0);
    rd(6'd5); tick(); idle();
    check("r5_data", 64'(read_set_out), 64'h0_1550_0000);
    check("r5_ev_vld_low", 64'(evict_valid_out), 64'd0);

    wr(6'd9, 2'd1, 10'h2AA); rd(6'd9); tick(); idle();
    check("wf9_data", 64'(read_set_out), 64'h0_000A_A800);
    check("wf9_rd_vld", 64'(read_valid_out), 64'd1);
    check("wf9_ev_vld", 64'(evict_valid_out), 64'd1);
    rd(6'd9); tick(); idle();
    check("r9_stored", 64'(read_set_out), 64'h0_000A_A800);

    wr(6'd3, 2'd0, 10'h011); tick();
    wr(6'd3, 2'd0, 10'h022); tick(); idle();
    check("w3_ev_vld", 64'(evict_valid_out), 64'd1);
    check("w3_ev_elem", 64'(evict_element_out), 64'h011);
    tick();
    check("hold_ev_vld", 64'(evict_valid_out), 64'd0);
    check("hold_ev_elem", 64'(evict_element_out), 64'h011);
    check("hold_rd_set", 64'(read_set_out), 64'h0_000A_A800);

    // Back-to-back: write a different set while reading, then same-set bypass
    wr(6'd5, 2'd3, 10'h0F0); rd(6'd3); tick();
    check("b2b_r3", 64'(read_set_out), 64'h0_0000_0022);
    check("b2b_ev0", 64'(evict_element_out), 64'd0);
    wr(6'd5, 2'd0, 10'h001); rd(6'd5); tick(); idle();
    check("b2b_r5_byp", 64'(read_set_out), 64'h3C_1550_0001);
    check("b2b_rd_vld", 64'(read_valid_out), 64'd1);
    rd(6'd5); tick(); idle();
    check("r5_stored", 64'(read_set_out), 64'h3C_1550_0001);

    // Reset mid-operation, then again mid-sweep
    reset_in = 1'b0; wr(6'd7, 2'd1, 10'h123); rd(6'd5); tick(); idle();
    check("rst2_rd_vld", 64'(read_valid_out), 64'd0);
    check("rst2_rd_set", 64'(read_set_out), 64'd0);
    check("rst2_ev_vld", 64'(evict_valid_out), 64'd0);
    check("rst2_done", 64'(init_done_out), 64'd0);
    reset_in = 1'b1;
    repeat (30) tick();
    reset_in = 1'b0; tick();
    check("rst3_done", 64'(init_done_out), 64'd0);
    reset_in = 1'b1;
    wait_init("reinit_latency");
    rd(6'd5); tick(); idle();
    check("reinit_r5", 64'(read_set_out), 64'd0);
    rd(6'd7); tick(); idle();
    check("reinit_r7", 64'(read_set_out), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
